// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl -- keypad front end for a two-operand 8-bit add/subtract
// calculator.
//
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   key_value[3:0]  0-9 digit, 10 add, 11 subtract, 14 clear, 15 equals,
//                   12/13 accepted but ignored
//   key_valid       high while a key is held
//   display[7:0]    operand_a / operand_b / result depending on phase
//   operand_a/b     stored operands
//   op_sub          0 add, 1 subtract
//   result, carry   last result and its carry-out / borrow
//   result_valid    one-cycle pulse when result updates
//   entry_err       sticky: a digit was rejected
//   phase[1:0]      0 ENTER_A, 1 ENTER_B, 2 RESULT
//
// Key path: key_valid/key_value -> key_qual (press qualifier, registered
// strobe) -> entry FSM. Operands change on the edge after the strobe cycle.

// Press qualifier: a press is accepted after DEBOUNCE consecutive samples of
// key_valid=1 with an unchanged code, then the qualifier disarms until
// key_valid has been low for DEBOUNCE consecutive samples. It comes out of
// reset disarmed, so a key already held at reset release is never taken.
module key_qual #(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_value,
  input  logic       key_valid,
  output logic       key_stb,
  output logic [3:0] key_code
);
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  logic       armed;
  logic [3:0] stab_cnt;
  logic [3:0] code;
  logic [3:0] rel_cnt;
  logic [3:0] cnt_nxt;

  // A code change restarts the count at 1 (this sample is the first stable one).
  always_comb begin
    cnt_nxt = 4'd1;
    if (stab_cnt != 4'd0 && key_value == code) cnt_nxt = stab_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed    <= 1'b0;
      stab_cnt <= '0;
      code     <= '0;
      rel_cnt  <= '0;
      key_stb  <= 1'b0;
      key_code <= '0;
    end else begin
      key_stb <= 1'b0;
      if (!armed) begin
        stab_cnt <= '0;
        if (key_valid) begin
          rel_cnt <= '0;
        end else if (rel_cnt == DB - 4'd1) begin
          armed   <= 1'b1;
          rel_cnt <= '0;
        end else begin
          rel_cnt <= rel_cnt + 4'd1;
        end
      end else if (!key_valid) begin
        stab_cnt <= '0;
      end else begin
        code <= key_value;
        if (cnt_nxt == DB) begin
          key_stb  <= 1'b1;
          key_code <= key_value;
          armed    <= 1'b0;
          stab_cnt <= '0;
        end else begin
          stab_cnt <= cnt_nxt;
        end
      end
    end
  end
endmodule

module calc_entry_ctrl #(
  parameter int DEBOUNCE   = 4,
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_value,
  input  logic       key_valid,
  output logic [7:0] display,
  output logic [7:0] operand_a,
  output logic [7:0] operand_b,
  output logic       op_sub,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       carry,
  output logic       entry_err,
  output logic [1:0] phase
);
  localparam int CW = $clog2(MAX_DIGITS + 2);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    RESULT  = 2'd2,
    BAD     = 2'd3
  } phase_t;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_CLR = 4'd14;
  localparam logic [3:0] K_EQ  = 4'd15;

  logic       key_stb;
  logic [3:0] key_code;

  key_qual #(.DEBOUNCE(DEBOUNCE)) u_qual (
    .clk      (clk),
    .rst      (rst),
    .key_value(key_value),
    .key_valid(key_valid),
    .key_stb  (key_stb),
    .key_code (key_code)
  );

  phase_t          phase_q,  phase_d;
  logic [7:0]      opa_q,    opa_d;
  logic [7:0]      opb_q,    opb_d;
  logic            sub_q,    sub_d;
  logic [7:0]      res_q,    res_d;
  logic            cy_q,     cy_d;
  logic            err_q,    err_d;
  logic            rv_q,     rv_d;
  logic [CW-1:0]   dcnt_q,   dcnt_d;

  // Digit accumulation in 12 bits so 255*10+9 cannot wrap before the check.
  logic [7:0]  acc_base;
  logic [11:0] acc_val;
  logic        acc_ok;
  logic [8:0]  sum9, diff9;
  logic        is_digit, is_op;

  always_comb begin
    acc_base = (phase_q == ENTER_B) ? opb_q : opa_q;
    acc_val  = {4'b0, acc_base} * 12'd10 + {8'b0, key_code};
    acc_ok   = (dcnt_q < CW'(MAX_DIGITS)) && (acc_val <= 12'd255);
    sum9     = {1'b0, opa_q} + {1'b0, opb_q};
    // Bit 8 of the 9-bit difference is exactly the borrow (opa < opb).
    diff9    = {1'b0, opa_q} - {1'b0, opb_q};
    is_digit = key_code <= 4'd9;
    is_op    = (key_code == K_ADD) || (key_code == K_SUB);
  end

  always_comb begin
    phase_d = phase_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sub_d   = sub_q;
    res_d   = res_q;
    cy_d    = cy_q;
    err_d   = err_q;
    rv_d    = 1'b0;
    dcnt_d  = dcnt_q;

    if (phase_q == BAD) begin
      phase_d = ENTER_A;
    end else if (key_stb) begin
      if (key_code == K_CLR) begin
        opa_d   = '0;
        opb_d   = '0;
        dcnt_d  = '0;
        sub_d   = 1'b0;
        err_d   = 1'b0;
        phase_d = ENTER_A;
      end else begin
        unique case (phase_q)
          ENTER_A: begin
            if (is_digit) begin
              if (acc_ok) begin
                opa_d  = acc_val[7:0];
                dcnt_d = dcnt_q + CW'(1);
              end else begin
                err_d = 1'b1;
              end
            end else if (is_op) begin
              sub_d   = (key_code == K_SUB);
              opb_d   = '0;
              dcnt_d  = '0;
              phase_d = ENTER_B;
            end
          end
          ENTER_B: begin
            if (is_digit) begin
              if (acc_ok) begin
                opb_d  = acc_val[7:0];
                dcnt_d = dcnt_q + CW'(1);
              end else begin
                err_d = 1'b1;
              end
            end else if (is_op) begin
              sub_d = (key_code == K_SUB);
            end else if (key_code == K_EQ) begin
              res_d   = sub_q ? diff9[7:0] : sum9[7:0];
              cy_d    = sub_q ? diff9[8]   : sum9[8];
              rv_d    = 1'b1;
              phase_d = RESULT;
            end
          end
          RESULT: begin
            if (is_digit) begin
              opa_d   = {4'b0, key_code};
              opb_d   = '0;
              dcnt_d  = CW'(1);
              phase_d = ENTER_A;
            end else if (is_op) begin
              // Chain: the last result becomes the new first operand.
              opa_d   = res_q;
              opb_d   = '0;
              dcnt_d  = '0;
              sub_d   = (key_code == K_SUB);
              phase_d = ENTER_B;
            end
          end
          default: phase_d = ENTER_A;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= ENTER_A;
      opa_q   <= '0;
      opb_q   <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    case (phase_q)
      ENTER_A: display = opa_q;
      ENTER_B: display = opb_q;
      RESULT:  display = res_q;
      default: display = '0;
    endcase
  end

  assign operand_a    = opa_q;
  assign operand_b    = opb_q;
  assign op_sub       = sub_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign carry        = cy_q;
  assign entry_err    = err_q;
  assign phase        = phase_q;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Scoreboard bench for calc_entry_ctrl (DEBOUNCE=4, MAX_DIGITS=3).
// Stimulus pushes expected {result, carry} before each equals press; the
// monitor pops on every result_valid pulse. Other state is checked directly.
module tb_calc_entry_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_value = '0;
  logic       key_valid = 1'b0;
  logic [7:0] display, operand_a, operand_b, result;
  logic       op_sub, result_valid, carry, entry_err;
  logic [1:0] phase;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];
  bit done = 1'b0;

  always #5 clk = ~clk;

  calc_entry_ctrl #(.DEBOUNCE(4), .MAX_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .key_value(key_value), .key_valid(key_valid),
    .display(display), .operand_a(operand_a), .operand_b(operand_b),
    .op_sub(op_sub), .result(result), .result_valid(result_valid),
    .carry(carry), .entry_err(entry_err), .phase(phase)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int code);
    key_value = 4'(code);
    key_valid = 1'b1;
    cyc(6);
    key_valid = 1'b0;
    cyc(6);
  endtask

  task automatic eq(input int res, input int cy);
    exp_q.push_back({1'(cy), 8'(res)});
    press(15);
  endtask

  // Monitor: every result_valid pulse must match the oldest expectation.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!done && result_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", int'(result), int'(e[7:0]));
          chk("sb_carry", int'(carry), int'(e[8]));
          chk("sb_phase", int'(phase), 2);
        end
      end
    end
  end

  initial begin
    cyc(3);
    chk("rst_phase", phase, 0);
    chk("rst_display", display, 0);
    chk("rst_opa", operand_a, 0);
    chk("rst_opb", operand_b, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {result_valid, carry, entry_err, op_sub}, 0);
    rst = 1'b0;
    cyc(6);

    // 123 + 45 = 168
    press(1); press(2); press(3);
    chk("a_123", operand_a, 123);
    chk("disp_a", display, 123);
    press(10);
    chk("phase_b", phase, 1);
    chk("opb_zero", operand_b, 0);
    press(11);
    chk("op_sub_set", op_sub, 1);
    press(10);
    chk("op_sub_overwrite", op_sub, 0);
    press(4); press(5);
    chk("b_45", operand_b, 45);
    chk("disp_b", display, 45);
    eq(168, 0);
    chk("phase_result", phase, 2);
    chk("disp_result", display, 168);

    // Clear keeps result; 200 + 100 = 44 carry
    press(14);
    chk("clr_phase", phase, 0);
    chk("clr_opa", operand_a, 0);
    chk("clr_keeps_result", result, 168);
    press(2); press(0); press(0); press(10);
    press(1); press(0); press(0);
    eq(44, 1);
    chk("res_44", result, 44);
    // Chain: 44 - 50 = 250 with borrow
    press(11);
    chk("chain_opa", operand_a, 44);
    chk("chain_sub", op_sub, 1);
    chk("chain_phase", phase, 1);
    press(5); press(0);
    eq(250, 1);
    chk("res_250", result, 250);

    // Equals and code 12 in RESULT do nothing (monitor flags any pulse)
    press(15);
    press(12);
    chk("ignored_phase", phase, 2);
    chk("ignored_result", result, 250);

    // Digit in RESULT starts a new entry
    press(3);
    chk("res_digit_phase", phase, 0);
    chk("res_digit_opa", operand_a, 3);
    chk("res_digit_opb", operand_b, 0);

    // Limit checks
    press(14);
    press(2); press(5); press(6);
    chk("lim_25", operand_a, 25);
    chk("lim_err", entry_err, 1);
    press(14);
    chk("clr_err", entry_err, 0);
    press(9); press(9); press(9); press(9);
    chk("lim_99", operand_a, 99);
    chk("lim_err2", entry_err, 1);

    // Held key gives one digit; bouncing key gives none
    press(14);
    key_value = 4'd7; key_valid = 1'b1;
    cyc(100);
    key_valid = 1'b0;
    cyc(6);
    chk("hold_7", operand_a, 7);
    key_value = 4'd3;
    for (int i = 0; i < 6; i++) begin
      key_valid = 1'b1; cyc(2);
      key_valid = 1'b0; cyc(2);
    end
    cyc(6);
    chk("bounce", operand_a, 7);

    // Reset mid-press discards it; held key not accepted after release of rst
    key_value = 4'd5; key_valid = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(2);
    chk("rst2_opa", operand_a, 0);
    chk("rst2_display", display, 0);
    chk("rst2_flags", {result_valid, carry, entry_err, op_sub, phase}, 0);
    chk("rst2_result", result, 0);
    rst = 1'b0;
    cyc(20);
    chk("held_after_rst", operand_a, 0);
    key_valid = 1'b0;
    cyc(6);
    press(5);
    chk("repress_5", operand_a, 5);

    cyc(4);
    chk("sb_drained", exp_q.size(), 0);
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/calc_entry_ctrl.md
CALC_ENTRY_CTRL -- requirements
Module: calc_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 4, is the number of consecutive slow-domain clk cycles a key state must be stable before it is accepted (range 1..15).
REQ-002 Parameter MAX_DIGITS, default 3, is the maximum decimal digits per operand.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 key_value  input  4  keypad code: 0-9 digit, 10 add, 11 subtract, 14 clear, 15 equals; 12, 13 ignored.
REQ-006 key_valid  input  1  high while a key is pressed and key_value is meaningful.
REQ-007 display  output  8  value to show: current entry, or result in RESULT phase.
REQ-008 operand_a  output  8  stored first operand.
REQ-009 operand_b  output  8  stored second operand.
REQ-010 op_sub  output  1  selected operation: 0 add, 1 subtract.
REQ-011 result  output  8  last computed result.
REQ-012 result_valid  output  1  one-cycle pulse when result updates.
REQ-013 carry  output  1  add carry-out or subtract borrow of last result.
REQ-014 entry_err  output  1  sticky flag: a digit was rejected.
REQ-015 phase  output  2  FSM state: 0 ENTER_A, 1 ENTER_B, 2 RESULT.

Function
REQ-016 Press qualifier SHALL accept a key only after key_valid=1 with unchanged key_value for DEBOUNCE consecutive cycles, producing exactly one internal key strobe per press.
REQ-017 A change of key_value while key_valid=1 SHALL restart the stability count; no strobe for the old code.
REQ-018 After a strobe, no further strobe SHALL occur until key_valid=0 for DEBOUNCE consecutive cycles (re-arm); holding a key never repeats.
REQ-019 Digit d in ENTER_A: if digits entered < MAX_DIGITS and operand_a*10+d <= 255, operand_a <= operand_a*10+d (intermediate in >=12 bits); otherwise digit discarded and entry_err <= 1.
REQ-020 Digit in ENTER_B: same rule applied to operand_b.
REQ-021 Add/subtract key in ENTER_A: op_sub set, operand_b <= 0, digit count cleared, phase -> ENTER_B; operand_a keeps its value (0 if no digits).
REQ-022 Add/subtract key in ENTER_B: op_sub overwritten, phase unchanged.
REQ-023 Equals in ENTER_B: next cycle result <= (operand_a ± operand_b) mod 256, carry <= bit 8 of add or (operand_a < operand_b) for subtract, result_valid pulses 1 cycle, phase -> RESULT.
REQ-024 Equals in ENTER_A or RESULT: ignored, no result_valid.
REQ-025 Digit in RESULT: operand_a <= d, digit count 1, operand_b <= 0, phase -> ENTER_A.
REQ-026 Add/subtract in RESULT: operand_a <= result (chaining), operand_b <= 0, op_sub set, phase -> ENTER_B.
REQ-027 Clear in any phase: operand_a, operand_b, digit count, op_sub, entry_err <= 0, phase -> ENTER_A; result and carry retained.
REQ-028 Codes 12, 13 SHALL consume the press (re-arm rules apply) with no state change.
REQ-029 display = operand_a in ENTER_A, operand_b in ENTER_B, result in RESULT.
REQ-030 Latency: state/operand update exactly one cycle after the strobe cycle.

Reset
REQ-031 On rst=1 all registers clear immediately: phase=ENTER_A, operands, result, display, op_sub, carry, entry_err, result_valid all 0; qualifier unarmed-idle (requires fresh press).
REQ-032 rst asserted mid-press or mid-entry SHALL discard the press; a key still held at deassertion SHALL NOT be accepted until released and re-pressed.
REQ-033 Phase code 3 is unreachable; if entered it SHALL return to ENTER_A next cycle.

Verification
REQ-034 Press 1,2,3, add, 4,5, equals (each held 6, released 6 cycles) -> result=168, carry=0, one result_valid pulse, phase=2.
REQ-035 Enter 200 + 100 = -> result=44, carry=1; then subtract, 50, = -> result=250, carry=1 (44<50).
REQ-036 Enter 2,5,6 -> operand_a=25, entry_err=1; enter 9,9,9,9 after clear -> operand_a=999 never; 99 then 9 rejected at 3-digit/255 limit -> operand_a=99, entry_err=1.
REQ-037 Hold digit 7 for 100 cycles -> exactly one accepted digit; bounce key_valid 1-0-1 each 2 cycles with DEBOUNCE=4 -> no strobe.
REQ-038 Assert rst while digit 5 held past DEBOUNCE-1 cycles -> no acceptance after deassert until release/re-press; all outputs 0 during reset.
